// File: rtl/spi_master_shifter.sv
// -----------------------------------------------------------------------------
// spi_master_shifter
//   SPI mode 0 (CPOL=0, CPHA=0) master shift engine. Takes a parallel word over
//   a valid/ready handshake, serialises it on mosi and assembles miso into
//   rx_data. bit_tick pulses once per sampling (rising sclk) edge and feeds the
//   shared bit Counter's enable; frame/bit state is owned here.
//
//   Optional feature macro: SPI_LSB_FIRST_EN
//     defined   : bit 0 shifted out first, first miso bit lands in rx_data[0]
//     undefined : MSB first, first miso bit lands in rx_data[DATA_W-1]
//
// Ports
//   clk, counter_rst     clock (posedge) / async active-low reset
//   clk_div              sclk half-period = clk_div+1 clocks, latched at accept
//   tx_data/valid/ready  transmit word handshake (ready == IDLE)
//   rx_data/rx_valid     captured word, one-cycle valid pulse
//   busy                 frame in progress
//   bit_tick             one pulse per sampled bit
//   sclk/mosi/miso/cs_n  SPI pins
// -----------------------------------------------------------------------------
module spi_master_shifter #(
    parameter int DATA_W = 8,
    parameter int DIV_W  = 8
) (
    input  logic              clk,
    input  logic              counter_rst,
    input  logic [DIV_W-1:0]  clk_div,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    output logic              busy,
    output logic              bit_tick,
    output logic              sclk,
    output logic              mosi,
    input  logic              miso,
    output logic              cs_n
);

    localparam int BCW = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [BCW-1:0] LAST_BIT = BCW'(DATA_W - 1);

    typedef enum logic [1:0] {IDLE, SETUP, SHIFT, HOLD} state_t;

    state_t            state;
    logic [DIV_W-1:0]  div_q;    // latched clk_div
    logic [DIV_W:0]    div_cnt;  // one extra bit so H = 2^DIV_W and 2H never wrap
    logic [DATA_W-1:0] sr;       // shared tx/rx shift register
    logic [BCW-1:0]    bit_cnt;

    logic              half_done;
    logic              hold_done;
    logic              first_bit;
    logic              next_bit;
    logic [DATA_W-1:0] sr_shift;

    assign tx_ready  = (state == IDLE);
    assign busy      = (state != IDLE);

    // div_cnt == H-1 ends a half period; div_cnt == 2H-1 ends HOLD
    assign half_done = (div_cnt == {1'b0, div_q});
    assign hold_done = (div_cnt == {div_q, 1'b1});

`ifdef SPI_LSB_FIRST_EN
    assign first_bit = tx_data[0];
    assign sr_shift  = {miso, sr[DATA_W-1:1]};
    assign next_bit  = sr[0];
`else
    assign first_bit = tx_data[DATA_W-1];
    assign sr_shift  = {sr[DATA_W-2:0], miso};
    assign next_bit  = sr[DATA_W-1];
`endif

    always_ff @(posedge clk or negedge counter_rst) begin
        if (!counter_rst) begin
            state    <= IDLE;
            div_q    <= '0;
            div_cnt  <= '0;
            sr       <= '0;
            bit_cnt  <= '0;
            rx_data  <= '0;
            rx_valid <= 1'b0;
            bit_tick <= 1'b0;
            sclk     <= 1'b0;
            mosi     <= 1'b0;
            cs_n     <= 1'b1;
        end else begin
            rx_valid <= 1'b0;
            bit_tick <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid && tx_ready) begin
                        sr      <= tx_data;
                        div_q   <= clk_div;
                        div_cnt <= '0;
                        bit_cnt <= '0;
                        cs_n    <= 1'b0;
                        sclk    <= 1'b0;
                        mosi    <= first_bit;
                        state   <= SETUP;
                    end
                end
                SETUP: begin
                    if (half_done) begin
                        // first rising edge: sample bit 0 of the frame
                        div_cnt  <= '0;
                        sclk     <= 1'b1;
                        sr       <= sr_shift;
                        bit_tick <= 1'b1;
                        state    <= SHIFT;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                SHIFT: begin
                    if (half_done) begin
                        div_cnt <= '0;
                        if (sclk) begin
                            sclk <= 1'b0;
                            if (bit_cnt == LAST_BIT) begin
                                state <= HOLD;
                            end else begin
                                bit_cnt <= bit_cnt + 1'b1;
                                mosi    <= next_bit;
                            end
                        end else begin
                            sclk     <= 1'b1;
                            sr       <= sr_shift;
                            bit_tick <= 1'b1;
                        end
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                HOLD: begin
                    // HOLD spans the last sclk-low half period plus H hold
                    // cycles, giving cs_n low for (2*DATA_W+2)*H in total.
                    if (hold_done) begin
                        div_cnt  <= '0;
                        cs_n     <= 1'b1;
                        rx_data  <= sr;
                        rx_valid <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        div_cnt <= div_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_master_shifter.sv
module tb_spi_master_shifter;
    localparam int DATA_W = 8;
    localparam int DIV_W  = 8;
    localparam int BUDGET = 8000;
`ifdef SPI_LSB_FIRST_EN
    localparam bit LSB = 1'b1;
`else
    localparam bit LSB = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              counter_rst = 1'b0;
    logic [DIV_W-1:0]  clk_div = '0;
    logic [DATA_W-1:0] tx_data = '0;
    logic              tx_valid = 1'b0;
    logic              tx_ready;
    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              busy;
    logic              bit_tick;
    logic              sclk;
    logic              mosi;
    logic              miso;
    logic              cs_n;

    spi_master_shifter #(.DATA_W(DATA_W), .DIV_W(DIV_W)) dut (
        .clk(clk), .counter_rst(counter_rst), .clk_div(clk_div),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy),
        .bit_tick(bit_tick), .sclk(sclk), .mosi(mosi), .miso(miso),
        .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // position in the word of the k-th bit on the wire
    function automatic int idx(input int k);
        return LSB ? k : DATA_W - 1 - k;
    endfunction

    // stimulus knobs for the next frame
    logic [DATA_W-1:0] miso_w = '0;
    bit                loop_en = 1'b0;

    // reference model state for the frame in flight
    bit                active = 1'b0;
    bit                b2b = 1'b0;
    logic [DATA_W-1:0] c_tx = '0;
    logic [DATA_W-1:0] c_miso = '0;
    bit                c_loop = 1'b0;
    int                c_h = 1;
    int                cyc = 0, acc_cyc = 0, last_rise = 0;
    int                cs_cnt = 0, tick_cnt = 0, rise_cnt = 0, rx_cnt = 0;
    logic              sclk_d = 1'b0;

    // slave: loopback, or the k-th wire bit taken from miso word
    always_comb begin
        miso = 1'b0;
        if (c_loop) miso = mosi;
        else if (rise_cnt < DATA_W) miso = c_miso[idx(rise_cnt)];
    end

    always @(negedge clk) begin
        cyc++;
        if (!counter_rst) begin
            active = 1'b0;
            b2b    = 1'b0;
            sclk_d = 1'b0;
        end else begin
            if (b2b) begin
                chk("b2b_cs_gap", cs_n, 1'b0);
                b2b = 1'b0;
            end
            if (!active) chk("cs_idle_high", cs_n, 1'b1);
            if (active) begin
                if (!cs_n) cs_cnt++;
                if (bit_tick) tick_cnt++;
                if (sclk && !sclk_d) begin
                    chk("tick_on_rise", bit_tick, 1'b1);
                    if (rise_cnt < DATA_W) chk("mosi_bit", mosi, c_tx[idx(rise_cnt)]);
                    if (rise_cnt == 0) chk("setup_len", cyc - acc_cyc, c_h + 1);
                    else               chk("sclk_period", cyc - last_rise, 2 * c_h);
                    last_rise = cyc;
                    rise_cnt++;
                end
            end
            if (rx_valid) begin
                rx_cnt++;
                chk("rx_valid_in_frame", active, 1'b1);
                if (active) begin
                    chk("rx_data", rx_data, c_loop ? c_tx : c_miso);
                    chk("cs_low_len", cs_cnt, (2 * DATA_W + 2) * c_h);
                    chk("tick_count", tick_cnt, DATA_W);
                    chk("sclk_rises", rise_cnt, DATA_W);
                end
                active = 1'b0;
            end
            if (tx_valid && tx_ready) begin
                if (rx_valid) b2b = 1'b1;
                active   = 1'b1;
                c_tx     = tx_data;
                c_h      = int'(clk_div) + 1;
                c_miso   = miso_w;
                c_loop   = loop_en;
                acc_cyc  = cyc;
                cs_cnt   = 0;
                tick_cnt = 0;
                rise_cnt = 0;
            end
            sclk_d = sclk;
        end
    end

    task automatic wait_ready();
        int n;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (tx_ready) break;
        end
        if (n == BUDGET) chk("ready_timeout", tx_ready, 1'b1);
    endtask

    task automatic wait_rx();
        int n;
        for (n = 0; n < BUDGET; n++) begin
            @(negedge clk);
            if (rx_valid) break;
        end
        if (n == BUDGET) chk("rx_timeout", rx_valid, 1'b1);
        @(posedge clk); #1;
    endtask

    // caller is at posedge+1; returns at posedge+1 after the accept edge
    task automatic send(input logic [DATA_W-1:0] d, input bit keep);
        tx_data  = d;
        tx_valid = 1'b1;
        wait_ready();
        @(posedge clk); #1;
        if (!keep) tx_valid = 1'b0;
    endtask

    initial begin
        int r0;
        // reset state
        repeat (3) @(negedge clk);
        chk("rst_cs_n", cs_n, 1'b1);
        chk("rst_sclk", sclk, 1'b0);
        chk("rst_mosi", mosi, 1'b0);
        chk("rst_ready", tx_ready, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_rx_valid", rx_valid, 1'b0);
        chk("rst_tick", bit_tick, 1'b0);
        chk("rst_rx_data", rx_data, '0);
        @(posedge clk); #1;
        counter_rst = 1'b1;
        @(posedge clk); #1;

        // loopback A5, H=1
        clk_div = 0; loop_en = 1'b1;
        send(8'hA5, 1'b0); wait_rx();
        chk("lb_a5", rx_data, 8'hA5);

        // H=4, miso tied high
        clk_div = 3; loop_en = 1'b0; miso_w = 8'hFF;
        send(8'h3C, 1'b0); wait_rx();
        chk("miso_ones", rx_data, 8'hFF);

        // back-to-back with tx_valid held
        clk_div = 0; loop_en = 1'b1; r0 = rx_cnt;
        tx_data = 8'h01; tx_valid = 1'b1;
        wait_ready(); @(posedge clk); #1;
        tx_data = 8'h80;
        wait_ready(); @(posedge clk); #1;
        tx_valid = 1'b0;
        wait_rx();
        chk("b2b_rx_count", rx_cnt - r0, 2);
        chk("b2b_last_rx", rx_data, 8'h80);

        // clk_div changed mid-frame: frame keeps H=1, next uses H=8
        clk_div = 0; loop_en = 1'b1;
        send(8'h5A, 1'b0);
        repeat (4) @(posedge clk); #1;
        clk_div = 7;
        wait_rx();
        send(8'hC3, 1'b0); wait_rx();
        chk("div8_rx", rx_data, 8'hC3);

        // LSB/MSB single-bit word in loopback
        clk_div = 0; loop_en = 1'b1;
        send(8'h01, 1'b0); wait_rx();
        chk("lb_01", rx_data, 8'h01);

        // randomized frames, including the all-ones divider
        for (int i = 0; i < 12; i++) begin
            clk_div = (i == 5) ? 8'hFF : DIV_W'($urandom_range(0, 4));
            loop_en = $urandom_range(0, 1) != 0;
            miso_w  = DATA_W'($urandom);
            send(DATA_W'($urandom), 1'b0);
            wait_rx();
            repeat ($urandom_range(0, 3)) @(posedge clk);
            #1;
        end

        // async reset mid-SHIFT
        clk_div = 1; loop_en = 1'b0; miso_w = 8'h96;
        send(8'h69, 1'b0);
        repeat (6) @(posedge clk);
        #2 counter_rst = 1'b0;
        #1;
        chk("arst_cs_n", cs_n, 1'b1);
        chk("arst_sclk", sclk, 1'b0);
        chk("arst_busy", busy, 1'b0);
        chk("arst_ready", tx_ready, 1'b1);
        chk("arst_rx_valid", rx_valid, 1'b0);
        chk("arst_tick", bit_tick, 1'b0);
        repeat (2) @(posedge clk);
        #1 counter_rst = 1'b1;
        r0 = rx_cnt;
        repeat (60) @(posedge clk);
        #1;
        chk("no_rx_after_rst", rx_cnt - r0, 0);

        // recovery frame
        clk_div = 2; loop_en = 1'b1;
        send(8'hE7, 1'b0); wait_rx();
        chk("recover_rx", rx_data, 8'hE7);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
